color_classifier_filt: RTL and testbench

- Parametrised, registered successor to the combinational RGB colour identifier.
- Takes normalised R/G/B samples with a valid strobe and classifies each into one of 8 colour codes.
- Debounces the classification: the output changes only after STABLE_CNT consecutive identical classifications.
- Sits between the sensor normaliser and the RGB LED / display driver.

---
 rtl/color_pkg.sv | 20 ++
 rtl/color_classifier_filt_classify.sv | 25 ++
 rtl/color_classifier_filt.sv | 103 ++++++++++
 tb/tb_color_classifier_filt.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/color_pkg.sv
// color_pkg: shared colour codes, code type and debounce counter width helper
package color_pkg;

    typedef logic [2:0] color_t;

    localparam color_t COL_BLACK   = 3'b000;
    localparam color_t COL_BLUE    = 3'b001;
    localparam color_t COL_GREEN   = 3'b010;
    localparam color_t COL_CYAN    = 3'b011;
    localparam color_t COL_RED     = 3'b100;
    localparam color_t COL_MAGENTA = 3'b101;
    localparam color_t COL_YELLOW  = 3'b110;
    localparam color_t COL_WHITE   = 3'b111;

    // counter must hold 0..stable_cnt inclusive
    function automatic int cnt_width(input int stable_cnt);
        return $clog2(stable_cnt + 1);
    endfunction

endpackage

// File: rtl/color_classifier_filt_classify.sv
// color_classify: combinational RGB to 3-bit active-high colour code
module color_classify
    import color_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] black_th,
    input  logic [DATA_W-1:0] white_th,
    output color_t            code
);

    // priority: dark, bright, then strictly-greatest channel, any max tie is cyan
    always_comb begin
        code = (r < black_th && g < black_th && b < black_th) ? COL_BLACK :
               (r > white_th && g > white_th && b > white_th) ? COL_WHITE :
               (r > g && r > b) ? ((g > b) ? COL_YELLOW : COL_RED) :
               (g > r && g > b) ? ((r > b) ? COL_YELLOW : COL_GREEN) :
               (b > r && b > g) ? ((r > g) ? COL_MAGENTA : COL_BLUE) :
               COL_CYAN;
    end

endmodule

// File: rtl/color_classifier_filt.sv
// color_classifier_filt: registered, debounced RGB colour classifier (optional runtime thresholds via COLOR_THRESH_PROG_EN)
module color_classifier_filt
    import color_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BLACK_TH   = 150,
    parameter int WHITE_TH   = 600,
    parameter int STABLE_CNT = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] red_norm,
    input  logic [DATA_W-1:0] green_norm,
    input  logic [DATA_W-1:0] blue_norm,
`ifdef COLOR_THRESH_PROG_EN
    input  logic [DATA_W-1:0] black_th,
    input  logic [DATA_W-1:0] white_th,
`endif
    output logic [2:0]        color,
    output logic              color_changed,
    output logic              locked,
    output logic [2:0]        raw_code
);

    localparam int CW = cnt_width(STABLE_CNT);
    localparam logic [CW-1:0] STABLE = CW'(STABLE_CNT);

    logic [DATA_W-1:0] w_black_th;
    logic [DATA_W-1:0] w_white_th;
    color_t            w_code;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_upd;

    color_t            r_raw_code;
    logic              r_raw_v;
    color_t            r_cand;
    logic [CW-1:0]     r_cnt;
    color_t            r_code;
    logic              r_changed;
    logic              r_locked;

`ifdef COLOR_THRESH_PROG_EN
    assign w_black_th = black_th;
    assign w_white_th = white_th;
`else
    assign w_black_th = DATA_W'(BLACK_TH);
    assign w_white_th = DATA_W'(WHITE_TH);
`endif

    color_classify #(.DATA_W(DATA_W)) u_classify (
        .r        (red_norm),
        .g        (green_norm),
        .b        (blue_norm),
        .black_th (w_black_th),
        .white_th (w_white_th),
        .code     (w_code)
    );

    // run length of the incoming code; a new code restarts the run at 1
    assign w_cnt_nxt = (r_raw_code == r_cand) ? ((r_cnt == STABLE) ? r_cnt : r_cnt + 1'b1) : CW'(1);
    // the candidate after this cycle is always raw_code when raw_v is set
    assign w_upd = r_raw_v && (w_cnt_nxt == STABLE) && (r_raw_code != r_code || !r_locked);

    // stage 1: capture classification of each valid sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raw_code <= COL_BLACK;
            r_raw_v    <= 1'b0;
        end else begin
            r_raw_v <= in_valid;
            if (in_valid) r_raw_code <= w_code;
        end
    end

    // stage 2: debounce run tracking and output code update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand    <= COL_BLACK;
            r_cnt     <= '0;
            r_code    <= COL_BLACK;
            r_changed <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            if (r_raw_v) begin
                r_cand <= r_raw_code;
                r_cnt  <= w_cnt_nxt;
            end
            r_changed <= w_upd;
            if (w_upd) begin
                r_code   <= r_raw_code;
                r_locked <= 1'b1;
            end
        end
    end

    assign color         = (ACTIVE_LOW != 0) ? ~r_code : r_code;
    assign color_changed = r_changed;
    assign locked        = r_locked;
    assign raw_code      = r_raw_code;

endmodule

// File: tb/tb_color_classifier_filt.sv
// tb_color_classifier_filt: directed self-checking bench for color_classifier_filt
module tb_color_classifier_filt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] red_norm = '0;
    logic [15:0] green_norm = '0;
    logic [15:0] blue_norm = '0;
`ifdef COLOR_THRESH_PROG_EN
    logic [15:0] black_th = 16'd150;
    logic [15:0] white_th = 16'd600;
`endif
    logic [2:0]  color;
    logic        color_changed;
    logic        locked;
    logic [2:0]  raw_code;

    int n_chk = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int p0;

    color_classifier_filt dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .red_norm      (red_norm),
        .green_norm    (green_norm),
        .blue_norm     (blue_norm),
`ifdef COLOR_THRESH_PROG_EN
        .black_th      (black_th),
        .white_th      (white_th),
`endif
        .color         (color),
        .color_changed (color_changed),
        .locked        (locked),
        .raw_code      (raw_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (color_changed) n_pulse++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int r, input int g, input int b);
        @(negedge clk);
        in_valid = 1'b1;
        red_norm = 16'(r);
        green_norm = 16'(g);
        blue_norm = 16'(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    initial begin
        idle(2);
        chk("reset_color", 8'(color), 8'h7);
        chk("reset_locked", 8'(locked), 8'h0);
        chk("reset_changed", 8'(color_changed), 8'h0);
        chk("reset_raw", 8'(raw_code), 8'h0);
        rst_n = 1'b1;
        // red (R greatest, G <= B) four times
        repeat (4) send(500, 50, 100);
        idle(1);
        chk("red_raw", 8'(raw_code), 8'h4);
        chk("red_color_pending", 8'(color), 8'h7);
        chk("red_locked_pending", 8'(locked), 8'h0);
        idle(1);
        chk("red_color", 8'(color), 8'h3);
        chk("red_pulse", 8'(color_changed), 8'h1);
        chk("red_locked", 8'(locked), 8'h1);
        idle(1);
        chk("red_pulse_end", 8'(color_changed), 8'h0);
        // yellow x3, green x1, yellow x3: run broken, no update
        p0 = n_pulse;
        repeat (3) send(400, 300, 100);
        send(100, 400, 200);
        idle(1);
        chk("green_raw", 8'(raw_code), 8'h2);
        repeat (3) send(400, 300, 100);
        idle(1);
        chk("yellow_raw", 8'(raw_code), 8'h6);
        idle(3);
        chk("broken_run_color", 8'(color), 8'h3);
        chk("broken_run_pulses", 8'(n_pulse - p0), 8'h0);
        // tie for maximum gives cyan
        repeat (4) send(300, 300, 100);
        idle(3);
        chk("cyan_raw", 8'(raw_code), 8'h3);
        chk("cyan_color", 8'(color), 8'h4);
        chk("cyan_pulses", 8'(n_pulse - p0), 8'h1);
        // white
        repeat (4) send(700, 700, 700);
        idle(3);
        chk("white_raw", 8'(raw_code), 8'h7);
        chk("white_color", 8'(color), 8'h0);
        // black just below threshold
        repeat (4) send(149, 10, 0);
        idle(3);
        chk("black_raw", 8'(raw_code), 8'h0);
        chk("black_color", 8'(color), 8'h7);
        // channel equal to BLACK_TH is not dark: R greatest, G > B gives yellow
        send(150, 10, 0);
        idle(1);
        chk("black_edge_raw", 8'(raw_code), 8'h6);
        // channel equal to WHITE_TH is not bright: G/B tie gives cyan
        send(600, 700, 700);
        idle(1);
        chk("white_edge_raw", 8'(raw_code), 8'h3);
        // magenta with idle gaps still completes the run
        p0 = n_pulse;
        repeat (4) begin
            send(200, 50, 400);
            idle(3);
        end
        idle(2);
        chk("magenta_raw", 8'(raw_code), 8'h5);
        chk("magenta_color", 8'(color), 8'h2);
        chk("magenta_pulses", 8'(n_pulse - p0), 8'h1);
        repeat (2) begin
            send(200, 50, 400);
            idle(3);
        end
        chk("magenta_repeat_pulses", 8'(n_pulse - p0), 8'h1);
        chk("magenta_repeat_color", 8'(color), 8'h2);
        // alternating blue / green never settles
        repeat (4) begin
            send(100, 200, 300);
            send(100, 400, 200);
        end
        idle(3);
        chk("alt_color", 8'(color), 8'h2);
        chk("alt_pulses", 8'(n_pulse - p0), 8'h1);
        // threshold override sample
`ifdef COLOR_THRESH_PROG_EN
        @(negedge clk);
        black_th = 16'd50;
        send(100, 80, 90);
        idle(1);
        chk("prog_th_raw", 8'(raw_code), 8'h4);
        black_th = 16'd150;
`else
        send(100, 80, 90);
        idle(1);
        chk("fixed_th_raw", 8'(raw_code), 8'h0);
`endif
        // asynchronous reset mid-stream
        send(500, 50, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_color", 8'(color), 8'h7);
        chk("midreset_locked", 8'(locked), 8'h0);
        chk("midreset_changed", 8'(color_changed), 8'h0);
        chk("midreset_raw", 8'(raw_code), 8'h0);
        idle(1);
        rst_n = 1'b1;
        // first accepted colour after reset, even black, pulses and locks
        p0 = n_pulse;
        repeat (4) send(10, 20, 30);
        idle(3);
        chk("post_reset_black_color", 8'(color), 8'h7);
        chk("post_reset_locked", 8'(locked), 8'h1);
        chk("post_reset_pulses", 8'(n_pulse - p0), 8'h1);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
